// File: rtl/sram_bank.sv
// 32K x 8 single-port SRAM bank with burst tracking, beat counters and
// sticky protocol error flags.
module sram_bank (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [14:0] sram_addr_r,
  inout  wire  [7:0]  sram_data,
  input  logic        sram_cs,
  input  logic        sram_oe,
  input  logic        sram_we,
  output logic        burst_done,
  output logic        burst_is_wr,
  output logic [14:0] burst_addr,
  output logic [12:0] burst_len,
  output logic [15:0] wr_total,
  output logic [15:0] rd_total,
  output logic        err_conflict,
  output logic        err_seq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  logic [7:0]  mem [0:32767];
  logic [1:0]  state;
  logic [14:0] exp_addr;
  logic [14:0] cur_start;
  logic [12:0] cur_len;

  logic wr_cyc, rd_cyc, cf_cyc, busy, same_kind, extend;

  // Bus contract: every cycle is one beat; the strobe pattern (all active low)
  // selects write, read, conflict or idle, and the beat completes at the edge.
  assign wr_cyc    = !sram_cs && !sram_we &&  sram_oe;
  assign rd_cyc    = !sram_cs && !sram_oe &&  sram_we;
  assign cf_cyc    = !sram_cs && !sram_oe && !sram_we;
  assign busy      = (state != ST_IDLE);
  assign same_kind = ((state == ST_WR) && wr_cyc) || ((state == ST_RD) && rd_cyc);
  assign extend    = same_kind && (sram_addr_r == exp_addr);

  assign sram_data = (rd_cyc && !sys_rst) ? mem[sram_addr_r] : 8'hzz;

  // Array has no reset; a write presented during reset is dropped.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && wr_cyc) begin
      mem[sram_addr_r] <= sram_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= ST_IDLE;
      exp_addr     <= '0;
      cur_start    <= '0;
      cur_len      <= '0;
      burst_done   <= 1'b0;
      burst_is_wr  <= 1'b0;
      burst_addr   <= '0;
      burst_len    <= '0;
      wr_total     <= '0;
      rd_total     <= '0;
      err_conflict <= 1'b0;
      err_seq      <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      if (wr_cyc) wr_total <= wr_total + 16'd1;
      if (rd_cyc) rd_total <= rd_total + 16'd1;
      if (cf_cyc) err_conflict <= 1'b1;

      if (extend) begin
        cur_len  <= (cur_len == 13'h1FFF) ? cur_len : cur_len + 13'd1;
        exp_addr <= exp_addr + 15'd1;
      end else begin
        // Any non-continuing beat closes the open burst; a new one may open
        // in the same edge while the outputs report the old one.
        if (busy) begin
          burst_done  <= 1'b1;
          burst_is_wr <= (state == ST_WR);
          burst_addr  <= cur_start;
          burst_len   <= cur_len;
        end
        if (same_kind) err_seq <= 1'b1;
        if (wr_cyc || rd_cyc) begin
          cur_start <= sram_addr_r;
          cur_len   <= 13'd1;
          exp_addr  <= sram_addr_r + 15'd1;
        end
        if (wr_cyc) begin
          state <= ST_WR;
        end else if (rd_cyc) begin
          state <= ST_RD;
        end else begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_bank.sv
// Directed bench for sram_bank: a scoreboard holds expected burst records and
// read data; a negedge monitor pops and compares whenever the DUT presents one.
module tb_sram_bank;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [14:0] sram_addr_r = '0;
  logic        sram_cs = 1'b1;
  logic        sram_oe = 1'b1;
  logic        sram_we = 1'b1;
  logic        tb_drive = 1'b0;
  logic [7:0]  tb_data = '0;
  wire  [7:0]  sram_data;
  logic        burst_done, burst_is_wr, err_conflict, err_seq;
  logic [14:0] burst_addr;
  logic [12:0] burst_len;
  logic [15:0] wr_total, rd_total;

  int checks = 0;
  int errors = 0;

  // Burst record: {is_wr, start address, length}
  logic [28:0] exp_q[$];
  logic [7:0]  rd_q[$];

  assign sram_data = tb_drive ? tb_data : 8'hzz;

  // Pull-ups make a released bus read as 8'hFF.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup pu (sram_data[i]);
  end

  sram_bank dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .sram_addr_r  (sram_addr_r),
    .sram_data    (sram_data),
    .sram_cs      (sram_cs),
    .sram_oe      (sram_oe),
    .sram_we      (sram_we),
    .burst_done   (burst_done),
    .burst_is_wr  (burst_is_wr),
    .burst_addr   (burst_addr),
    .burst_len    (burst_len),
    .wr_total     (wr_total),
    .rd_total     (rd_total),
    .err_conflict (err_conflict),
    .err_seq      (err_seq)
  );

  // Clock / watchdog
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time exceeded, got timeout required finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change at posedge+1, beat completes at next posedge.
  task automatic cyc(input logic cs, input logic oe, input logic we,
                     input logic [14:0] a, input logic drv, input logic [7:0] d);
    sram_cs = cs; sram_oe = oe; sram_we = we;
    sram_addr_r = a; tb_drive = drv; tb_data = d;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [14:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b1, 1'b0, a, 1'b1, d);
  endtask

  task automatic rd(input logic [14:0] a, input logic [7:0] exp_d);
    rd_q.push_back(exp_d);
    cyc(1'b0, 1'b0, 1'b1, a, 1'b0, 8'h00);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b1, 1'b1, 15'h0, 1'b0, 8'h00);
  endtask

  task automatic push_burst(input logic is_wr, input logic [14:0] a, input logic [12:0] len);
    exp_q.push_back({is_wr, a, len});
  endtask

  // Monitor
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (burst_done) begin
        if (exp_q.size() == 0) begin
          chk("burst_unexpected", {3'b0, burst_is_wr, burst_addr, burst_len}, 32'hFFFF_FFFF);
        end else begin
          chk("burst_record", {3'b0, burst_is_wr, burst_addr, burst_len}, {3'b0, exp_q.pop_front()});
        end
      end
      if (!sram_cs && !sram_oe && sram_we) begin
        if (rd_q.size() == 0) begin
          chk("read_unexpected", {24'b0, sram_data}, 32'hFFFF_FFFF);
        end else begin
          chk("read_data", {24'b0, sram_data}, {24'b0, rd_q.pop_front()});
        end
      end
    end
  end

  // Stimulus
  initial begin
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_burst_done", burst_done, 0);
    chk("rst_burst_regs", {burst_is_wr, burst_addr, burst_len}, 0);
    chk("rst_totals", {wr_total, rd_total}, 0);
    chk("rst_errs", {err_conflict, err_seq}, 0);
    sys_rst = 1'b0;

    // Write 0x40..0x43 then read them back directly; write burst closes on first read edge
    push_burst(1'b1, 15'h0040, 13'd4);
    for (int i = 0; i < 4; i++) wr(15'h0040 + 15'(i), 8'hA0 + 8'(i));
    push_burst(1'b0, 15'h0040, 13'd4);
    for (int i = 0; i < 4; i++) rd(15'h0040 + 15'(i), 8'hA0 + 8'(i));
    idle();
    idle();
    chk("wr_total_4", wr_total, 4);
    chk("rd_total_4", rd_total, 4);

    // Address wrap inside a burst
    push_burst(1'b1, 15'h7FFE, 13'd3);
    wr(15'h7FFE, 8'h11); wr(15'h7FFF, 8'h22); wr(15'h0000, 8'h33);
    idle();
    push_burst(1'b0, 15'h0000, 13'd1);
    rd(15'h0000, 8'h33);
    idle();
    idle();
    chk("err_seq_wrap", err_seq, 0);
    chk("wr_total_7", wr_total, 7);
    chk("rd_total_5", rd_total, 5);

    // Non-sequential write splits the burst
    push_burst(1'b1, 15'h0010, 13'd1);
    push_burst(1'b1, 15'h0020, 13'd1);
    wr(15'h0010, 8'h44); wr(15'h0020, 8'h66);
    idle();
    idle();
    chk("err_seq_set", err_seq, 1);
    chk("err_conflict_clear", err_conflict, 0);
    chk("wr_total_9", wr_total, 9);

    // Conflict cycles: no write, no drive, counters frozen
    push_burst(1'b1, 15'h0005, 13'd1);
    wr(15'h0005, 8'h3C);
    idle();
    cyc(1'b0, 1'b0, 1'b0, 15'h0005, 1'b1, 8'h55);
    sram_cs = 1'b0; sram_oe = 1'b0; sram_we = 1'b0;
    sram_addr_r = 15'h0005; tb_drive = 1'b0;
    #3;
    chk("conflict_hiz", sram_data, 8'hFF);
    @(posedge sys_clk);
    #1;
    idle();
    chk("err_conflict_set", err_conflict, 1);
    chk("wr_total_conflict", wr_total, 10);
    chk("rd_total_conflict", rd_total, 5);
    push_burst(1'b0, 15'h0005, 13'd1);
    rd(15'h0005, 8'h3C);
    idle();
    idle();
    chk("rd_total_6", rd_total, 6);

    // Length saturation: 8193 sequential beats report 8191
    push_burst(1'b1, 15'h1000, 13'd8191);
    for (int i = 0; i < 8193; i++) wr(15'h1000 + 15'(i), 8'(i));
    idle();
    idle();
    chk("wr_total_sat", wr_total, 8203);

    // Reset mid-burst discards the burst; write during reset is dropped
    push_burst(1'b1, 15'h0103, 13'd1);
    wr(15'h0103, 8'h77);
    idle();
    idle();
    for (int i = 0; i < 3; i++) wr(15'h0100 + 15'(i), 8'hC1 + 8'(i));
    sys_rst = 1'b1;
    wr(15'h0103, 8'hEE);
    sram_cs = 1'b0; sram_oe = 1'b0; sram_we = 1'b1;
    sram_addr_r = 15'h0040; tb_drive = 1'b0;
    #3;
    chk("rst_read_hiz", sram_data, 8'hFF);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    idle();
    chk("midrst_burst_regs", {burst_done, burst_is_wr, burst_addr, burst_len}, 0);
    chk("midrst_totals", {wr_total, rd_total}, 0);
    chk("midrst_errs", {err_conflict, err_seq}, 0);
    push_burst(1'b0, 15'h0100, 13'd4);
    for (int i = 0; i < 3; i++) rd(15'h0100 + 15'(i), 8'hC1 + 8'(i));
    rd(15'h0103, 8'h77);
    idle();
    idle();
    chk("rd_total_after_rst", rd_total, 4);
    chk("wr_total_after_rst", wr_total, 0);

    repeat (3) idle();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
